// File: rtl/aud_pkg.sv
// Shared constants and helpers for the audio PWM modulator.
package aud_pkg;

   localparam int unsigned SAMPLE_W_DEF     = 8;
   localparam int unsigned IDLE_PERIODS_DEF = 1024;

   // Midscale duty: output sits at half supply, so start-up causes no pop.
   function automatic int unsigned aud_midscale(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/aud_sample_buf.sv
// One-deep sample buffer: holds the next duty value until the period wrap takes it.
module aud_sample_buf
   import aud_pkg::*;
#(
   parameter int unsigned W = SAMPLE_W_DEF
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [W-1:0] sample_i,
   input  logic         valid_i,
   input  logic         take_i,
   output logic         ready_o,
   output logic         full_o,
   output logic [W-1:0] data_o
);

   logic         full_q, full_d;
   logic [W-1:0] data_q, data_d;
   logic         accept;

   // Accept is only possible while empty, so it never collides with a take of real data.
   assign accept = valid_i && !full_q;

   always_comb begin
      // NOTE: every signal gets its default first, so no path can leave it unassigned and infer a latch.
      full_d = full_q;
      data_d = data_q;
      if (accept) begin
         full_d = 1'b1;
         data_d = sample_i;
      end else if (take_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         // NOTE: the data register is reset for X-free simulation only; full_q alone decides whether it is valid.
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         // NOTE: non-blocking updates keep every flop sampling pre-edge values.
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign ready_o = !full_q;
   assign full_o  = full_q;
   assign data_o  = data_q;

endmodule

// File: rtl/aud_pwm_mod.sv
// Audio PWM modulator with period-aligned duty loading.
// Optional idle shutdown of the amplifier is enabled by defining AUD_IDLE_SHUTDOWN_EN.
module aud_pwm_mod
   import aud_pkg::*;
#(
   parameter int unsigned SAMPLE_W     = SAMPLE_W_DEF,
   parameter int unsigned IDLE_PERIODS = IDLE_PERIODS_DEF
) (
   input  logic                Clk_100M,
   input  logic                Reset_n,
   input  logic [SAMPLE_W-1:0] Sample,
   input  logic                Sample_Valid,
   output logic                Sample_Ready,
   output logic                Period_Start,
   output logic                Underrun,
   output logic                AUD_PWM,
   output logic                AUD_SD
);

   localparam logic [SAMPLE_W-1:0] DUTY_RST = SAMPLE_W'(aud_midscale(SAMPLE_W));
   localparam logic [SAMPLE_W-1:0] CNT_MAX  = '1;

   logic [SAMPLE_W-1:0] cnt_q, cnt_d;
   logic [SAMPLE_W-1:0] duty_q, duty_d;
   logic [SAMPLE_W-1:0] pend_data;
   logic                pend_full;
   logic                wrap, load;
   logic                pwm_q, pwm_d;
   logic                under_q, under_d;
   logic                sd_q, sd_d;

   assign wrap = (cnt_q == CNT_MAX);
   assign load = wrap && pend_full;

   aud_sample_buf #(
      .W (SAMPLE_W)
   ) u_buf (
      .clk_i    (Clk_100M),
      .rst_n_i  (Reset_n),
      .sample_i (Sample),
      .valid_i  (Sample_Valid),
      .take_i   (wrap),
      .ready_o  (Sample_Ready),
      .full_o   (pend_full),
      .data_o   (pend_data)
   );

`ifdef AUD_IDLE_SHUTDOWN_EN
   localparam int unsigned       IDLE_W   = $clog2(IDLE_PERIODS + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_PERIODS);
   localparam logic              SD_RST   = 1'b0;

   logic [IDLE_W-1:0] idle_q, idle_d;

   // Counts consecutive starved wraps; the amplifier wakes on the first real load.
   always_comb begin
      idle_d = idle_q;
      sd_d   = sd_q;
      if (load) begin
         idle_d = '0;
         sd_d   = 1'b1;
      end else if (wrap) begin
         if (idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);
         if (idle_d == IDLE_MAX) sd_d = 1'b0;
      end
   end

   always_ff @(posedge Clk_100M or negedge Reset_n) begin
      if (!Reset_n) idle_q <= '0;
      else          idle_q <= idle_d;
   end
`else
   localparam logic SD_RST = 1'b1;

   // IDLE_PERIODS has no role without idle shutdown.
   logic unused_idle;
   assign unused_idle = ^IDLE_PERIODS;
   assign sd_d        = 1'b1;
`endif

   assign cnt_d   = cnt_q + SAMPLE_W'(1);
   assign duty_d  = load ? pend_data : duty_q;
   assign under_d = wrap && !pend_full;
   assign pwm_d   = sd_d && (cnt_q < duty_q);

   always_ff @(posedge Clk_100M or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q   <= '0;
         duty_q  <= DUTY_RST;
         pwm_q   <= 1'b0;
         under_q <= 1'b0;
         sd_q    <= SD_RST;
      end else begin
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
         pwm_q   <= pwm_d;
         under_q <= under_d;
         sd_q    <= sd_d;
      end
   end

   assign Period_Start = (cnt_q == '0);
   assign Underrun     = under_q;
   assign AUD_PWM      = pwm_q;
   assign AUD_SD       = sd_q;

endmodule
